tcdm_bank_amo_stub: RTL and testbench
=====================================

Name: tcdm_bank_amo_stub

Overview:
- Bank-side model that sits directly downstream of the TCDM adapter in a tile and consumes its bank request stream.
- Implements single-port word SRAM storage with 1-cycle read latency and in-bank read-modify-write atomics.
- Returns responses with the request metadata (ini_addr/meta_id/tile_id/core_id/lrwait) echoed unchanged.
- Response path has a small FIFO so the adapter's output stall (resp_ready_i low) never loses data.

Parameters:
- DataWidth, 32, word width in bits; strobe width is DataWidth/8.
- NumWords, 1024, bank depth in words; power of two.
- MetaWidth, 20, width of the opaque metadata bundle carried with each request.
- RespFifoDepth, 2, response FIFO entries; minimum 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  $clog2(NumWords)  word address.
- req_write_i  in  1  store (ignored when req_amo_i!=0).
- req_amo_i  in  4  atomic opcode, 0 = none.
- req_wdata_i  in  DataWidth  store/AMO operand.
- req_be_i  in  DataWidth/8  byte enables (stores only; AMOs are full-word).
- req_meta_i  in  MetaWidth  metadata, returned verbatim.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when valid&ready.
- resp_rdata_o  out  DataWidth  load data or old AMO value.
- resp_meta_o  out  MetaWidth  echoed metadata.

Behaviour:
- Reset: rst_i sampled on the clock edge.
  - FSM goes to IDLE; FIFO emptied; in-flight flag cleared.
  - resp_valid_o=0, resp_rdata_o=0, resp_meta_o=0; req_ready_o=0 during the reset cycle.
  - SRAM contents are NOT cleared.
  - Reset mid-AMO aborts the writeback; memory keeps its pre-AMO value.
- Opcodes:
  - 1 SWAP, 2 ADD, 3 AND, 4 OR, 5 XOR, 6 MAX (signed), 7 MAXU, 8 MIN (signed), 9 MINU.
  - 10-15 are treated as opcode 0.
- Request classes:
  - Load: amo=0, write=0. Produces 1 response with mem[addr] read in the acceptance cycle, visible in the FIFO the next cycle.
  - Store: amo=0, write=1. Byte-masked write at the acceptance edge. Produces NO response.
  - AMO: amo in 1..9. Produces 1 response carrying the old value.
- FSM states: IDLE, AMO_WB.
  - IDLE to AMO_WB on AMO acceptance; captures addr, opcode, operand and read data.
  - AMO_WB: writes op(old, operand) at addr, then returns to IDLE unconditionally (1 cycle).
  - ADD wraps modulo 2^DataWidth.
- Ready rule: req_ready_o = IDLE && !rst_i && (FIFO occupancy + inflight < RespFifoDepth).
  - inflight = 1 while a load/AMO read is being pushed.
  - req_ready_o is independent of req_valid_i (no combinational valid-to-ready path).
- Latency:
  - Load/AMO response is earliest at resp_valid_o the cycle after acceptance.
  - Throughput is 1 load/store per cycle; an AMO occupies 2 cycles.
- Read-after-write: a load accepted the cycle after a store or AMO writeback to the same address returns the new value. The SRAM is write-first; no stale-read hazard exists.
- FIFO:
  - Push and pop in the same cycle is allowed when full (occupancy unchanged).
  - Ordering is strictly FIFO; responses match request acceptance order.
- resp_valid_o stays high with rdata/meta held stable until resp_ready_i.

Test Plan:
- Store addr 5 data 0xDEADBEEF be=0xF; load addr 5 with meta 0x12345 -> 1 response rdata 0xDEADBEEF, meta 0x12345; no response for the store.
- Store 0xFFFFFFFF to addr 3, then store 0x00000000 to addr 3 with be=0x2, then load addr 3 -> rdata 0xFFFF00FF.
- mem[7]=0x7FFFFFFF; AMO ADD operand 1 at addr 7 -> response 0x7FFFFFFF; req_ready_o low 1 cycle; later load -> 0x80000000. Repeat with mem=0xFFFFFFFF -> wraps to 0.
- mem[9]=0xFFFFFFFE (-2), AMO MAX operand 1 -> memory 1; same start with MAXU -> memory unchanged 0xFFFFFFFE; MINU operand 1 -> 1.
- Hold resp_ready_i=0, issue 4 back-to-back loads -> exactly RespFifoDepth(2) accepted, then req_ready_o=0. Release ready -> responses in issue order, then the remaining loads are accepted.
- Assert rst_i in the AMO_WB cycle of AMO SWAP 0xAAAA on mem=0x1111 -> after reset, FIFO empty, resp_valid_o=0, and a load returns 0x1111.

Source files
------------

// File: rtl/tcdm_bank_amo_stub.sv
// Purpose: TCDM bank model with word SRAM, byte-masked stores, in-bank read-modify-write AMOs and metadata-echoing responses.
// Latency: a load/AMO response is valid the cycle after acceptance; an AMO holds the bank for 2 cycles (read, then writeback).
// Backpressure: req_ready_o drops while queued plus in-flight responses would exceed RespFifoDepth; responses are held until resp_ready_i.
// Ports: clk_i/rst_i (synchronous, active-high); req_* request channel (valid/ready, addr/write/amo/wdata/be/meta);
//        resp_* response channel (valid/ready, rdata/meta).

// Generic synchronous FIFO used for the response queue.
// Latency: an entry pushed at an edge is at head_o after that edge if the FIFO was empty.
// Backpressure: the caller guarantees no push while full unless it pops in the same cycle.
module tcdm_bank_amo_stub_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic [CntW-1:0]  cnt_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
endmodule

module tcdm_bank_amo_stub #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned NumWords      = 1024,
  parameter int unsigned MetaWidth     = 20,
  parameter int unsigned RespFifoDepth = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [$clog2(NumWords)-1:0] req_addr_i,
  input  logic                        req_write_i,
  input  logic [3:0]                  req_amo_i,
  input  logic [DataWidth-1:0]        req_wdata_i,
  input  logic [DataWidth/8-1:0]      req_be_i,
  input  logic [MetaWidth-1:0]        req_meta_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [DataWidth-1:0]        resp_rdata_o,
  output logic [MetaWidth-1:0]        resp_meta_o
);
  localparam int unsigned AddrW    = $clog2(NumWords);
  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned CntW     = $clog2(RespFifoDepth + 1);
  localparam int unsigned SumW     = CntW + 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] AMO_WB = 1'b1;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [MetaWidth-1:0] meta;
  } resp_t;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [0:0]           state_q, state_d;
  logic [AddrW-1:0]     amo_addr_q;
  logic [3:0]           amo_op_q;
  logic [DataWidth-1:0] amo_opnd_q;
  logic [DataWidth-1:0] rdata_q;
  logic [MetaWidth-1:0] meta_q;
  logic                 inflight_q;

  logic                 is_amo, req_acc, store_acc, read_acc;
  logic [DataWidth-1:0] amo_new;
  logic                 fifo_push, fifo_pop, fifo_empty;
  logic [CntW-1:0]      fifo_cnt;
  resp_t                stage, fifo_head, resp_out;

  // Opcodes 10..15 decode as "no AMO", so they fall back to load/store.
  assign is_amo = (req_amo_i >= 4'd1) && (req_amo_i <= 4'd9);

  // In-flight read counts against the FIFO so its push next cycle always has room.
  assign req_ready_o = (state_q == IDLE) && !rst_i &&
                       ((SumW'(fifo_cnt) + SumW'(inflight_q)) < SumW'(RespFifoDepth));

  assign req_acc   = req_valid_i && req_ready_o;
  assign store_acc = req_acc && !is_amo && req_write_i;
  assign read_acc  = req_acc && (is_amo || !req_write_i);

  always_comb begin
    state_d = state_q;
    if (state_q == AMO_WB)      state_d = IDLE;
    else if (req_acc && is_amo) state_d = AMO_WB;
  end

  // rdata_q still holds the old word during AMO_WB: no request is accepted in that cycle.
  always_comb begin
    amo_new = rdata_q;
    case (amo_op_q)
      4'd1: amo_new = amo_opnd_q;
      4'd2: amo_new = rdata_q + amo_opnd_q;
      4'd3: amo_new = rdata_q & amo_opnd_q;
      4'd4: amo_new = rdata_q | amo_opnd_q;
      4'd5: amo_new = rdata_q ^ amo_opnd_q;
      4'd6: amo_new = ($signed(rdata_q) > $signed(amo_opnd_q)) ? rdata_q : amo_opnd_q;
      4'd7: amo_new = (rdata_q > amo_opnd_q) ? rdata_q : amo_opnd_q;
      4'd8: amo_new = ($signed(rdata_q) < $signed(amo_opnd_q)) ? rdata_q : amo_opnd_q;
      4'd9: amo_new = (rdata_q < amo_opnd_q) ? rdata_q : amo_opnd_q;
      default: amo_new = rdata_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      rdata_q    <= '0;
      meta_q     <= '0;
      amo_addr_q <= '0;
      amo_op_q   <= '0;
      amo_opnd_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= read_acc;
      if (read_acc) begin
        rdata_q <= mem_q[req_addr_i];
        meta_q  <= req_meta_i;
      end
      if (req_acc && is_amo) begin
        amo_addr_q <= req_addr_i;
        amo_op_q   <= req_amo_i;
        amo_opnd_q <= req_wdata_i;
      end
    end
  end

  // Single port: a store and an AMO writeback never share a cycle, and a read is never
  // accepted in the writeback cycle, so reads always see the latest written value.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (store_acc) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (req_be_i[b]) mem_q[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
        end
      end else if (state_q == AMO_WB) begin
        mem_q[amo_addr_q] <= amo_new;
      end
    end
  end

  // The freshly read word bypasses the FIFO when it is empty; it is queued only if not taken.
  assign stage     = {rdata_q, meta_q};
  assign fifo_pop  = resp_ready_i && !fifo_empty;
  assign fifo_push = inflight_q && !(fifo_empty && resp_ready_i);

  tcdm_bank_amo_stub_fifo #(
    .Width ($bits(resp_t)),
    .Depth (RespFifoDepth),
    .CntW  (CntW)
  ) u_resp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_dat_i (stage),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .cnt_o      (fifo_cnt)
  );

  assign resp_out     = fifo_empty ? stage : fifo_head;
  assign resp_valid_o = !fifo_empty || inflight_q;
  assign resp_rdata_o = resp_out.rdata;
  assign resp_meta_o  = resp_out.meta;
endmodule

// File: tb/tb_tcdm_bank_amo_stub.sv
// Purpose: self-checking bench for tcdm_bank_amo_stub: table of load/store/AMO vectors plus
// hand-written sequences for AMO port occupancy, response backpressure and reset during writeback.
module tb_tcdm_bank_amo_stub;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_write_i;
  logic [3:0]    req_amo_i;
  logic [DW-1:0] req_wdata_i;
  logic [3:0]    req_be_i;
  logic [MW-1:0] req_meta_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic [MW-1:0] resp_meta_o;

  always #5 clk_i = ~clk_i;

  tcdm_bank_amo_stub dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_write_i  (req_write_i),
    .req_amo_i    (req_amo_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .req_meta_i   (req_meta_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_meta_o  (resp_meta_o)
  );

  typedef struct {
    logic [3:0]    amo;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [MW-1:0] meta;
    bit            has_resp;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [MW-1:0] meta;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] amo, input logic wr, input int addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [19:0] meta, input bit has, input logic [31:0] exp);
    vec_t v;
    v.amo = amo; v.wr = wr; v.addr = AW'(addr); v.wdata = wdata; v.be = be;
    v.meta = meta; v.has_resp = has; v.exp = exp;
    return v;
  endfunction

  task automatic expect_resp(input vec_t v);
    exp_t e;
    e.rdata = v.exp;
    e.meta  = v.meta;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    req_amo_i   = v.amo;
    req_write_i = v.wr;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_be_i    = v.be;
    req_meta_i  = v.meta;
    req_valid_i = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the request.
  task automatic issue(input vec_t v);
    drive(v);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        if (v.has_resp) expect_resp(v);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout addr=%0d got no req_ready_o expected accept within 50 cycles", v.addr);
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // Scoreboard: every response handshake must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && resp_valid_o && resp_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got rdata=%h meta=%h expected no response", resp_rdata_o, resp_meta_o);
      end else begin
        e = sb.pop_front();
        if (resp_rdata_o !== e.rdata || resp_meta_o !== e.meta) begin
          errors++;
          $display("FAIL resp_data got rdata=%h meta=%h expected rdata=%h meta=%h",
                   resp_rdata_o, resp_meta_o, e.rdata, e.meta);
        end
      end
    end
  end

  initial begin
    vec_t lds[4];
    int   k;
    logic acc;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_write_i = 1'b0; req_amo_i = '0;
    req_wdata_i = '0; req_be_i = '0; req_meta_i = '0; resp_ready_i = 1'b1;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_rdata", resp_rdata_o, 0);
    chk("rst_resp_meta", resp_meta_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_req_ready", req_ready_o, 1);
    @(posedge clk_i); #1;

    // amo, write, addr, wdata, be, meta, has_resp, expected rdata
    tbl.push_back(mk(0, 1, 5,  32'hDEADBEEF, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(0, 0, 5,  32'h0,        4'hF, 20'h12345, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 3,  32'hFFFFFFFF, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3,  32'h00000000, 4'h2, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3,  32'h0,        4'hF, 20'h00001, 1, 32'hFFFF00FF));
    tbl.push_back(mk(0, 1, 7,  32'h7FFFFFFF, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(2, 0, 7,  32'h1,        4'hF, 20'h00002, 1, 32'h7FFFFFFF));
    tbl.push_back(mk(0, 0, 7,  32'h0,        4'hF, 20'h00003, 1, 32'h80000000));
    tbl.push_back(mk(0, 1, 7,  32'hFFFFFFFF, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(2, 1, 7,  32'h1,        4'hF, 20'h00004, 1, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 0, 7,  32'h0,        4'hF, 20'h00005, 1, 32'h00000000));
    tbl.push_back(mk(0, 1, 9,  32'hFFFFFFFE, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(6, 0, 9,  32'h1,        4'hF, 20'h00006, 1, 32'hFFFFFFFE));
    tbl.push_back(mk(0, 0, 9,  32'h0,        4'hF, 20'h00007, 1, 32'h00000001));
    tbl.push_back(mk(0, 1, 9,  32'hFFFFFFFE, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(7, 0, 9,  32'h1,        4'hF, 20'h00008, 1, 32'hFFFFFFFE));
    tbl.push_back(mk(0, 0, 9,  32'h0,        4'hF, 20'h00009, 1, 32'hFFFFFFFE));
    tbl.push_back(mk(9, 0, 9,  32'h1,        4'hF, 20'h0000A, 1, 32'hFFFFFFFE));
    tbl.push_back(mk(0, 0, 9,  32'h0,        4'hF, 20'h0000B, 1, 32'h00000001));
    tbl.push_back(mk(0, 1, 10, 32'h12345678, 4'hF, 20'h00000, 0, 32'h0));
    tbl.push_back(mk(1, 0, 10, 32'hCAFEF00D, 4'hF, 20'h0000C, 1, 32'h12345678));
    tbl.push_back(mk(3, 0, 10, 32'h0F0F0F0F, 4'hF, 20'h0000D, 1, 32'hCAFEF00D));
    tbl.push_back(mk(4, 0, 10, 32'h10000000, 4'hF, 20'h0000E, 1, 32'h0A0E000D));
    tbl.push_back(mk(5, 0, 10, 32'hFFFFFFFF, 4'hF, 20'h0000F, 1, 32'h1A0E000D));
    tbl.push_back(mk(8, 0, 10, 32'h5,        4'hF, 20'h00010, 1, 32'hE5F1FFF2));
    tbl.push_back(mk(0, 0, 10, 32'h0,        4'hF, 20'h00011, 1, 32'hE5F1FFF2));
    tbl.push_back(mk(12, 0, 10, 32'h0,       4'hF, 20'h00012, 1, 32'hE5F1FFF2));
    tbl.push_back(mk(12, 1, 10, 32'h55,      4'hF, 20'h00013, 0, 32'h0));
    tbl.push_back(mk(0, 0, 10, 32'h0,        4'hF, 20'h00014, 1, 32'h00000055));

    for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);

    // AMO holds the port for exactly one extra cycle; response is valid right after acceptance.
    issue(mk(0, 1, 12, 32'h7FFFFFFF, 4'hF, 20'h00000, 0, 32'h0));
    issue(mk(2, 0, 12, 32'h1,        4'hF, 20'hA0001, 1, 32'h7FFFFFFF));
    @(negedge clk_i);
    chk("amo_wb_ready_low", req_ready_o, 0);
    chk("amo_resp_latency", resp_valid_o, 1);
    @(negedge clk_i);
    chk("amo_ready_back", req_ready_o, 1);
    @(posedge clk_i); #1;
    issue(mk(0, 0, 12, 32'h0, 4'hF, 20'hA0002, 1, 32'h80000000));
    repeat (3) @(posedge clk_i); #1;

    // Backpressure: only RespFifoDepth loads get in while the consumer stalls.
    lds[0] = mk(0, 0, 5,  32'h0, 4'hF, 20'hB0000, 1, 32'hDEADBEEF);
    lds[1] = mk(0, 0, 3,  32'h0, 4'hF, 20'hB0001, 1, 32'hFFFF00FF);
    lds[2] = mk(0, 0, 9,  32'h0, 4'hF, 20'hB0002, 1, 32'h00000001);
    lds[3] = mk(0, 0, 10, 32'h0, 4'hF, 20'hB0003, 1, 32'h00000055);
    resp_ready_i = 1'b0;
    k = 0;
    drive(lds[0]);
    for (int cyc = 0; cyc < 60 && k < 4; cyc++) begin
      @(negedge clk_i);
      if (cyc == 6) begin
        chk("bp_accepted", k, 2);
        chk("bp_req_ready", req_ready_o, 0);
        chk("bp_resp_valid", resp_valid_o, 1);
        chk("bp_head_rdata", resp_rdata_o, 32'hDEADBEEF);
        chk("bp_head_meta", resp_meta_o, 20'hB0000);
      end
      acc = req_ready_o;
      if (acc) expect_resp(lds[k]);
      @(posedge clk_i); #1;
      if (cyc == 6) resp_ready_i = 1'b1;
      if (acc) begin
        k++;
        if (k < 4) drive(lds[k]);
      end
    end
    req_valid_i = 1'b0;
    chk("bp_all_accepted", k, 4);
    repeat (4) @(posedge clk_i); #1;

    // Reset during AMO writeback: pending response dropped, memory keeps the old word.
    issue(mk(0, 1, 11, 32'h00001111, 4'hF, 20'h00000, 0, 32'h0));
    resp_ready_i = 1'b0;
    issue(mk(1, 0, 11, 32'h0000AAAA, 4'hF, 20'hC0000, 0, 32'h0));
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_amo_req_ready", req_ready_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_amo_resp_valid", resp_valid_o, 0);
    chk("rst_amo_resp_rdata", resp_rdata_o, 0);
    chk("rst_amo_resp_meta", resp_meta_o, 0);
    chk("rst_amo_req_ready_after", req_ready_o, 1);
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;
    issue(mk(0, 0, 11, 32'h0, 4'hF, 20'hC0001, 1, 32'h00001111));

    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk_i);
    @(negedge clk_i);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
